// File: rtl/timing_profile_selector_if.sv
// Handshake/bus bundle between the menu side (master) and the timing
// profile selector (slave): buttons, external load, player handshake,
// preview values, display values and the committed timing set.
interface timing_profile_selector_if;
    logic        ui_active;
    logic        btn_down;
    logic        btn_up;
    logic        btn_field;
    logic        btn_back;
    logic        btn_enter;
    logic        ext_set;
    logic [3:0]  ext_level;
    logic [3:0]  ext_tone;
    logic        demo_busy;
    logic        demo_done;
    logic        demo_start;
    logic        demo_abort;
    logic [31:0] prev_unit;
    logic [15:0] prev_tone_hz;
    logic        disp_field;
    logic [3:0]  disp_level;
    logic [3:0]  disp_tone;
    logic [31:0] dit_time;
    logic [31:0] dah_time;
    logic [31:0] dit_gap;
    logic [31:0] long_key_cycles;
    logic [31:0] timeout_cycles;
    logic [31:0] space_cycles;
    logic [15:0] tone_freq;
    logic        settings_applied;
    logic        back_requested;

    modport master (
        output ui_active, btn_down, btn_up, btn_field, btn_back, btn_enter,
               ext_set, ext_level, ext_tone, demo_busy, demo_done,
        input  demo_start, demo_abort, prev_unit, prev_tone_hz, disp_field,
               disp_level, disp_tone, dit_time, dah_time, dit_gap,
               long_key_cycles, timeout_cycles, space_cycles, tone_freq,
               settings_applied, back_requested
    );

    modport slave (
        input  ui_active, btn_down, btn_up, btn_field, btn_back, btn_enter,
               ext_set, ext_level, ext_tone, demo_busy, demo_done,
        output demo_start, demo_abort, prev_unit, prev_tone_hz, disp_field,
               disp_level, disp_tone, dit_time, dah_time, dit_gap,
               long_key_cycles, timeout_cycles, space_cycles, tone_freq,
               settings_applied, back_requested
    );
endinterface

// File: rtl/timing_profile_selector.sv
// Manual speed/tone settings page: edits a working level/tone, commits on
// ENTER, reverts on BACK, and loops a preview on the piezo player with a
// restart delay before every (re)start.
module timing_profile_selector #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int NUM_LEVELS   = 8,
    parameter int BASE_UNIT_MS = 250,
    parameter int NUM_TONES    = 8,
    parameter int TONE_MIN_HZ  = 400,
    parameter int TONE_STEP_HZ = 100,
    parameter int RESTART_MS   = 50
) (
    input  logic                        clk,
    input  logic                        rst_n,
    timing_profile_selector_if.slave    bus
);

    // Unit table numerator: twice the level-0 dit unit in cycles.
    localparam longint unsigned UNIT2       = ((64'(BASE_UNIT_MS) * 64'(CLK_HZ)) / 64'd1000) * 64'd2;
    localparam longint unsigned RESTART_CYC = (64'(RESTART_MS) * 64'(CLK_HZ)) / 64'd1000;
    // WAIT spends RESTART_CYC cycles (cnt 0..RESTART_CYC-1) before the start pulse.
    localparam logic [31:0] CNT_TERM = (RESTART_CYC > 0) ? 32'(RESTART_CYC - 64'd1) : 32'd0;
    localparam logic [3:0]  MAX_LVL  = 4'(NUM_LEVELS - 1);
    localparam logic [3:0]  MAX_TONE = 4'(NUM_TONES - 1);
    localparam logic [31:0] U0       = 32'(UNIT2 / 64'd2);
    localparam logic [15:0] TONE0    = 16'(TONE_MIN_HZ);

    typedef enum logic [1:0] {ST_OFF, ST_WAIT, ST_PLAY, ST_IDLE} state_t;

    function automatic logic [15:0] tone_hz(input logic [3:0] idx);
        return 16'(TONE_MIN_HZ + int'(idx) * TONE_STEP_HZ);
    endfunction

    // Constant unit table; unused slots above NUM_LEVELS repeat the last level.
    logic [31:0] w_unit_tab [16];
    for (genvar k = 0; k < 16; k++) begin : g_unit
        localparam int KK = (k < NUM_LEVELS) ? k : NUM_LEVELS - 1;
        assign w_unit_tab[k] = 32'(UNIT2 / 64'(KK + 2));
    end

    state_t      r_state;
    logic [31:0] r_cnt;
    logic        r_start, r_abort;
    logic        r_ui_d;
    logic [3:0]  r_work_lvl, r_work_tone, r_sav_lvl, r_sav_tone;
    logic        r_field;
    logic [31:0] r_dit, r_dah, r_gap, r_long, r_tmo, r_space;
    logic [15:0] r_tone_freq;
    logic        r_applied, r_back;

    logic        w_rise, w_btn_ok, w_enter, w_back, w_work_chg, w_cmt_load;
    logic        w_field_nxt;
    logic [3:0]  w_ext_lvl, w_ext_tone, w_lvl_nxt, w_tone_nxt, w_cmt_lvl, w_cmt_tone;
    logic [31:0] w_cmt_unit;

    assign w_rise     = bus.ui_active & ~r_ui_d;
    // Buttons act only on an already-open page and never alongside ext_set.
    assign w_btn_ok   = bus.ui_active & r_ui_d & ~bus.ext_set;
    assign w_enter    = w_btn_ok & bus.btn_enter;
    assign w_back     = w_btn_ok & bus.btn_back;
    assign w_ext_lvl  = (bus.ext_level > MAX_LVL)  ? MAX_LVL  : bus.ext_level;
    assign w_ext_tone = (bus.ext_tone  > MAX_TONE) ? MAX_TONE : bus.ext_tone;
    assign w_cmt_load = bus.ext_set | w_enter;
    assign w_cmt_lvl  = bus.ext_set ? w_ext_lvl  : r_work_lvl;
    assign w_cmt_tone = bus.ext_set ? w_ext_tone : r_work_tone;
    assign w_cmt_unit = w_unit_tab[w_cmt_lvl];

    // Next working level/tone/field: ext_set > page open > BACK > FIELD > step.
    always_comb begin
        w_lvl_nxt   = r_work_lvl;
        w_tone_nxt  = r_work_tone;
        w_field_nxt = r_field;
        if (bus.ext_set) begin
            w_lvl_nxt  = w_ext_lvl;
            w_tone_nxt = w_ext_tone;
        end else if (w_rise) begin
            w_lvl_nxt   = r_sav_lvl;
            w_tone_nxt  = r_sav_tone;
            w_field_nxt = 1'b0;
        end else if (w_btn_ok && !bus.btn_enter) begin
            if (bus.btn_back) begin
                w_lvl_nxt  = r_sav_lvl;
                w_tone_nxt = r_sav_tone;
            end else if (bus.btn_field) begin
                w_field_nxt = ~r_field;
            end else if (bus.btn_up && !bus.btn_down) begin
                if (!r_field && r_work_lvl  != MAX_LVL)  w_lvl_nxt  = r_work_lvl  + 4'd1;
                if ( r_field && r_work_tone != MAX_TONE) w_tone_nxt = r_work_tone + 4'd1;
            end else if (bus.btn_down && !bus.btn_up) begin
                if (!r_field && r_work_lvl  != 4'd0) w_lvl_nxt  = r_work_lvl  - 4'd1;
                if ( r_field && r_work_tone != 4'd0) w_tone_nxt = r_work_tone - 4'd1;
            end
        end
    end

    assign w_work_chg = (w_lvl_nxt != r_work_lvl) || (w_tone_nxt != r_work_tone);

    // Working/saved/committed settings and the commit/back pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ui_d      <= 1'b0;
            r_work_lvl  <= 4'd0;
            r_work_tone <= 4'd0;
            r_field     <= 1'b0;
            r_sav_lvl   <= 4'd0;
            r_sav_tone  <= 4'd0;
            r_dit       <= U0;
            r_dah       <= U0 * 32'd3;
            r_gap       <= U0;
            r_long      <= U0 * 32'd2;
            r_tmo       <= U0 * 32'd6;
            r_space     <= U0 * 32'd12;
            r_tone_freq <= TONE0;
            r_applied   <= 1'b0;
            r_back      <= 1'b0;
        end else begin
            r_ui_d      <= bus.ui_active;
            r_work_lvl  <= w_lvl_nxt;
            r_work_tone <= w_tone_nxt;
            r_field     <= w_field_nxt;
            r_applied   <= w_enter;
            r_back      <= w_back;
            if (w_cmt_load) begin
                r_sav_lvl   <= w_cmt_lvl;
                r_sav_tone  <= w_cmt_tone;
                r_dit       <= w_cmt_unit;
                r_dah       <= w_cmt_unit * 32'd3;
                r_gap       <= w_cmt_unit;
                r_long      <= w_cmt_unit * 32'd2;
                r_tmo       <= w_cmt_unit * 32'd6;
                r_space     <= w_cmt_unit * 32'd12;
                r_tone_freq <= tone_hz(w_cmt_tone);
            end
        end
    end

    // Preview loop: OFF -> WAIT (restart delay) -> PLAY, IDLE after leaving the edit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_OFF;
            r_cnt   <= 32'd0;
            r_start <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            r_start <= 1'b0;
            r_abort <= 1'b0;
            if (!bus.ui_active) begin
                r_abort <= (r_state == ST_PLAY);
                r_state <= ST_OFF;
                r_cnt   <= 32'd0;
            end else begin
                case (r_state)
                    ST_OFF: if (w_rise) begin
                        r_state <= ST_WAIT;
                        r_cnt   <= 32'd0;
                    end
                    ST_WAIT: begin
                        if (w_enter || w_back) begin
                            r_state <= ST_IDLE;
                        end else if (w_work_chg) begin
                            r_cnt <= 32'd0;
                        end else if (r_cnt == CNT_TERM) begin
                            r_start <= 1'b1;
                            r_state <= ST_PLAY;
                            r_cnt   <= 32'd0;
                        end else begin
                            r_cnt <= r_cnt + 32'd1;
                        end
                    end
                    ST_PLAY: begin
                        if (w_enter || w_back) begin
                            r_abort <= 1'b1;
                            r_state <= ST_IDLE;
                        end else if (w_work_chg) begin
                            r_abort <= 1'b1;
                            r_state <= ST_WAIT;
                            r_cnt   <= 32'd0;
                        end else if (bus.demo_done) begin
                            r_state <= ST_WAIT;
                            r_cnt   <= 32'd0;
                        end
                    end
                    ST_IDLE: if (w_work_chg) begin
                        r_state <= ST_WAIT;
                        r_cnt   <= 32'd0;
                    end
                    default: r_state <= ST_OFF;
                endcase
            end
        end
    end

    assign bus.demo_start       = r_start;
    assign bus.demo_abort       = r_abort;
    assign bus.prev_unit        = w_unit_tab[r_work_lvl];
    assign bus.prev_tone_hz     = tone_hz(r_work_tone);
    assign bus.disp_field       = r_field;
    assign bus.disp_level       = r_work_lvl;
    assign bus.disp_tone        = r_work_tone;
    assign bus.dit_time         = r_dit;
    assign bus.dah_time         = r_dah;
    assign bus.dit_gap          = r_gap;
    assign bus.long_key_cycles  = r_long;
    assign bus.timeout_cycles   = r_tmo;
    assign bus.space_cycles     = r_space;
    assign bus.tone_freq        = r_tone_freq;
    assign bus.settings_applied = r_applied;
    assign bus.back_requested   = r_back;

endmodule
